// File: rtl/regfile_wb_pkg.sv
// Shared constants for the picoMIPS register file and the instruction decoder.
`ifndef REGFILE_WB_PKG_MACROS
`define REGFILE_WB_PKG_MACROS
`define REG_SIZE  [7:0]
`define IMM_SIZE  [4:0]
`define ADDR_SIZE [2:0]
`endif

package regfile_wb_pkg;
    localparam int unsigned REG_W      = 8;
    localparam int unsigned IMM_W      = 5;
    localparam int unsigned REG_ADDR_W = 3;

    // Special register addresses shared with the decoder
    localparam int unsigned ZERO_REG = 0;
    localparam int unsigned SW_REG   = 1;
    localparam int unsigned LED_REG  = 2;
endpackage

// File: rtl/regfile_wb_sync2.sv
// Parameter-width two-flop synchroniser with asynchronous active-high reset.
module regfile_wb_sync2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/regfile_wb.sv
// Register file with one-entry write-back pipeline, read bypass, and switch/LED I/O mapping.
module regfile_wb #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned SW_REG   = regfile_wb_pkg::SW_REG,
    parameter int unsigned LED_REG  = regfile_wb_pkg::LED_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic `REG_SIZE    rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic `REG_SIZE    rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic `REG_SIZE    wr_data,
    input  logic `REG_SIZE    sw_in,
    output logic `REG_SIZE    leds
);
    import regfile_wb_pkg::*;

    logic [REG_W-1:0]  regs [NUM_REGS];
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [REG_W-1:0]  pend_data;
    logic [REG_W-1:0]  sw_sync;
    logic              wr_accept;

    regfile_wb_sync2 #(.W(REG_W)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_sync)
    );

    // Writes to the zero register and the switch register are dropped
    assign wr_accept = wr_en
                    && (wr_addr != ADDR_W'(ZERO_REG))
                    && (wr_addr != ADDR_W'(SW_REG));

    // Stage 1 captures the request; stage 2 commits the previous one on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            leds       <= '0;
        end else begin
            pend_valid <= wr_accept;
            if (wr_accept) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
            if (pend_valid) begin
                regs[pend_addr] <= pend_data;
                if (pend_addr == ADDR_W'(LED_REG)) begin
                    leds <= pend_data;
                end
            end
        end
    end

    function automatic logic [REG_W-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [REG_W-1:0]  sw,
        input logic              pv,
        input logic [ADDR_W-1:0] pa,
        input logic [REG_W-1:0]  pd,
        input logic [REG_W-1:0]  arr [NUM_REGS]
    );
        logic [REG_W-1:0] r;
        r = arr[addr];
        if (addr == ADDR_W'(ZERO_REG)) begin
            r = '0;
        end else if (addr == ADDR_W'(SW_REG)) begin
            r = sw;
        end else if (pv && (pa == addr)) begin
            r = pd;
        end
        return r;
    endfunction

    always_comb begin
        rd_data_a = read_mux(rd_addr_a, sw_sync, pend_valid, pend_addr, pend_data, regs);
        rd_data_b = read_mux(rd_addr_b, sw_sync, pend_valid, pend_addr, pend_data, regs);
    end
endmodule
